// File: rtl/add16u_err_monitor.sv
// add16u_err_monitor
// Watches the output of a 16-bit approximate adder and collects error statistics
// over a fixed window of samples: sum of |err| (saturating), worst-case |err|,
// and the number of erroneous results. Each accepted sample passes through a
// two-stage pipeline (signed difference, then magnitude) before it reaches the
// statistic registers. After the window, the FSM drains the pipeline and then
// pulses done.

module add16u_err_monitor #(
  parameter int WIDTH       = 16,
  parameter int NUM_SAMPLES = 256,
  parameter int ACC_W       = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   o_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH:0]   max_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // The accumulator sum is formed one bit wider than the wider operand, so an
  // overflow past ACC_W bits is visible and can be clamped.
  localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
  localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t state;
  state_t state_next;

  logic clear_stats;
  logic done_set;
  logic accept;
  logic last_accept;

  logic [WIDTH:0]          exact;
  logic signed [WIDTH+1:0] d_comb;
  logic                    s1_valid;
  logic signed [WIDTH+1:0] s1_d;
  logic [WIDTH:0]          abs_e;
  logic                    s2_valid;
  logic [WIDTH:0]          s2_e;

  logic [SUM_W-1:0] sum_wide;
  logic [ACC_W-1:0] sum_next;

  assign in_ready    = (state == RUN) && (sample_count < NUM_CNT);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (sample_count == LAST_IDX);

  // The exact sum is zero-extended, then the approximate sum is subtracted with
  // one extra sign bit, so both over- and underestimates are representable.
  assign exact  = {1'b0, a} + {1'b0, b};
  assign d_comb = $signed({1'b0, exact}) - $signed({1'b0, o_approx});

  // |d| always fits in WIDTH+1 bits, so negating only the low bits is exact.
  assign abs_e = s1_d[WIDTH+1] ? (~s1_d[WIDTH:0] + 1'b1) : s1_d[WIDTH:0];

  // A widened sum detects overflow past ACC_W and clamps it to all-ones.
  assign sum_wide = SUM_W'(sum_abs_err) + SUM_W'(s2_e);
  assign sum_next = (|sum_wide[SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

  // Next state: start is honoured only when idle or finished; drain waits for stage 1 to empty.
  always_comb begin
    state_next  = state;
    clear_stats = 1'b0;
    done_set    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next  = RUN;
          clear_stats = 1'b1;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid) begin
          state_next = DONE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and the one-cycle done pulse that marks entry into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_set;
    end
  end

  // Two pipeline stages: first the signed difference, then its magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_d     <= '0;
      s2_e     <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) begin
        s1_d <= d_comb;
      end
      if (s1_valid) begin
        s2_e <= abs_e;
      end
    end
  end

  // Window statistics: clear on start, count accepts, fold each magnitude in when it leaves stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_count <= '0;
      sum_abs_err  <= '0;
      max_err      <= '0;
      err_count    <= '0;
    end else if (clear_stats) begin
      sample_count <= '0;
      sum_abs_err  <= '0;
      max_err      <= '0;
      err_count    <= '0;
    end else begin
      if (accept) begin
        sample_count <= sample_count + 1'b1;
      end
      if (s2_valid) begin
        sum_abs_err <= sum_next;
        if (s2_e > max_err) begin
          max_err <= s2_e;
        end
        err_count <= err_count + {{(CNT_W-1){1'b0}}, (s2_e != '0)};
      end
    end
  end

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Testbench for add16u_err_monitor.
// The same stimulus drives two instances, one with a 32-bit accumulator and one
// with a 16-bit accumulator. A behavioural model tracks the window phase, counts
// accepts and applies each |a+b-o| two edges after it was accepted. On every
// falling edge, a compare process checks both instances against the model.
// The individual scenarios also check hand-computed literal results.

module tb_add16u_err_monitor;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [16:0] o_approx;

  logic        in_ready_32, busy_32, done_32;
  logic [31:0] sum_32;
  logic [16:0] max_32;
  logic [15:0] errc_32, cnt_32;

  logic        in_ready_16, busy_16, done_16;
  logic [15:0] sum_16;
  logic [16:0] max_16;
  logic [15:0] errc_16, cnt_16;

  int total = 0;
  int bad   = 0;

  // model state
  typedef struct {
    longint due;
    int     e;
  } upd_t;

  upd_t   q[$];
  int     m_phase = 0;
  int     m_count = 0;
  int     m_drain = 0;
  int     m_max   = 0;
  int     m_errc  = 0;
  longint m_sum   = 0;
  bit     m_done  = 1'b0;
  longint edge_no = 0;
  longint last_acc_edge = 0;

  add16u_err_monitor #(.WIDTH(16), .NUM_SAMPLES(N), .ACC_W(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_32),
    .a(a), .b(b), .o_approx(o_approx), .busy(busy_32), .done(done_32),
    .sum_abs_err(sum_32), .max_err(max_32), .err_count(errc_32), .sample_count(cnt_32)
  );

  add16u_err_monitor #(.WIDTH(16), .NUM_SAMPLES(N), .ACC_W(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_16),
    .a(a), .b(b), .o_approx(o_approx), .busy(busy_16), .done(done_16),
    .sum_abs_err(sum_16), .max_err(max_16), .err_count(errc_16), .sample_count(cnt_16)
  );

  always #5 clk = ~clk;

  function automatic longint sat(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a phase variable, an accept counter and a queue of pending updates.
  initial begin : model
    upd_t u;
    int   e;
    forever begin
      @(posedge clk);
      edge_no++;
      if (rst) begin
        q.delete();
        m_phase = 0; m_count = 0; m_drain = 0;
        m_sum = 0; m_max = 0; m_errc = 0; m_done = 1'b0;
      end else begin
        while (q.size() > 0 && q[0].due == edge_no) begin
          u = q.pop_front();
          m_sum += u.e;
          if (u.e > m_max) m_max = u.e;
          if (u.e != 0) m_errc++;
        end
        m_done = 1'b0;
        case (m_phase)
          0, 3: begin
            if (start) begin
              m_phase = 1;
              m_sum = 0; m_max = 0; m_errc = 0; m_count = 0;
            end
          end
          1: begin
            if (in_valid && m_count < N) begin
              e = int'(a) + int'(b) - int'(o_approx);
              if (e < 0) e = -e;
              u.due = edge_no + 2;
              u.e   = e;
              q.push_back(u);
              m_count++;
              if (m_count == N) begin
                m_phase = 2;
                m_drain = 2;
              end
            end
          end
          2: begin
            m_drain--;
            if (m_drain == 0) begin
              m_phase = 3;
              m_done  = 1'b1;
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison of both instances against the model, away from the active edge.
  initial begin : compare
    logic exp_ready, exp_busy;
    forever begin
      @(negedge clk);
      exp_ready = (m_phase == 1) && (m_count < N);
      exp_busy  = (m_phase == 1) || (m_phase == 2);
      check_output("ready32", in_ready_32, exp_ready);
      check_output("busy32",  busy_32,     exp_busy);
      check_output("done32",  done_32,     m_done);
      check_output("sum32",   sum_32,      sat(m_sum, 32));
      check_output("max32",   max_32,      m_max);
      check_output("errc32",  errc_32,     m_errc);
      check_output("cnt32",   cnt_32,      m_count);
      check_output("ready16", in_ready_16, exp_ready);
      check_output("busy16",  busy_16,     exp_busy);
      check_output("done16",  done_16,     m_done);
      check_output("sum16",   sum_16,      sat(m_sum, 16));
      check_output("max16",   max_16,      m_max);
      check_output("errc16",  errc_16,     m_errc);
      check_output("cnt16",   cnt_16,      m_count);
    end
  end

  // Drive one cycle of inputs; mode picks how o_approx relates to a+b.
  task automatic apply_stimulus(input int mode, input bit valid, input bit start_v);
    int idx;
    idx      = m_count;
    start    = start_v;
    in_valid = valid;
    a        = 16'($urandom);
    b        = 16'($urandom);
    o_approx = {1'b0, a} + {1'b0, b};
    if (!valid) begin
      o_approx = 17'($urandom);
    end else begin
      case (mode)
        1: if ($urandom_range(0, 3) == 0) o_approx = 17'($urandom);
        2: if (idx == 77) begin a = 16'hFFFF; b = 16'hFFFF; o_approx = 17'h00000; end
        3: begin a = 16'h0000; b = 16'h0000; o_approx = 17'h1FFFF; end
        default: ;
      endcase
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ready"}, {in_ready_32, in_ready_16}, 2'b00);
    check_output({tag, "_busy"},  {busy_32, busy_16},         2'b00);
    check_output({tag, "_done"},  {done_32, done_16},         2'b00);
    check_output({tag, "_sum"},   {sum_32, sum_16},           48'h0);
    check_output({tag, "_max"},   {max_32, max_16},           34'h0);
    check_output({tag, "_errc"},  {errc_32, errc_16},         32'h0);
    check_output({tag, "_cnt"},   {cnt_32, cnt_16},           32'h0);
  endtask

  // Pulse start for one cycle; with b2b the caller is already in the done cycle.
  task automatic start_window(input bit b2b);
    if (!b2b) begin
      in_valid = 1'b0;
      repeat (2) step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Feed samples until limit have been accepted (bounded by a cycle budget).
  task automatic feed(input int mode, input bit toggle, input bit noisy, input int limit);
    int cyc;
    for (cyc = 0; cyc < 4 * N + 20; cyc++) begin
      if (m_count >= limit) break;
      apply_stimulus(mode, toggle ? (cyc % 2 == 0) : 1'b1, noisy && (cyc % 9 == 4));
      step();
    end
    last_acc_edge = edge_no;
    check_output("feed_accepts", m_count >= limit, 1'b1);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Drain and wait for done; optionally pulse start during the first drain cycle.
  task automatic finish_window(input bit start_in_drain);
    bit seen;
    seen     = 1'b0;
    in_valid = 1'b0;
    start    = start_in_drain;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_32 === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check_output("done_seen", seen, 1'b1);
    check_output("done_latency", (edge_no + 1) - last_acc_edge, 64'd3);
    check_output("done_ready", {in_ready_32, in_ready_16}, 2'b00);
  endtask

  initial begin : stimulus
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; o_approx = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_all_zero("reset");

    // reset in the middle of a window discards everything
    start_window(1'b0);
    feed(1, 1'b0, 1'b0, 10);
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    step();
    start_window(1'b0);
    feed(1, 1'b0, 1'b0, N);
    finish_window(1'b0);
    check_output("full_after_rst_cnt", cnt_32, 16'd256);

    // exact adder
    start_window(1'b0);
    feed(0, 1'b0, 1'b0, N);
    finish_window(1'b0);
    check_output("exact_sum", sum_32, 32'd0);
    check_output("exact_max", max_32, 17'd0);
    check_output("exact_errc", errc_32, 16'd0);
    check_output("exact_cnt", cnt_32, 16'd256);

    // single large underestimate
    start_window(1'b0);
    feed(2, 1'b0, 1'b0, N);
    finish_window(1'b0);
    check_output("single_max", max_32, 17'd131070);
    check_output("single_sum", sum_32, 32'd131070);
    check_output("single_errc", errc_32, 16'd1);
    check_output("single_sum16", sum_16, 16'hFFFF);

    // constant overestimate saturates the narrow accumulator
    start_window(1'b0);
    feed(3, 1'b0, 1'b0, N);
    finish_window(1'b0);
    check_output("over_sum16", sum_16, 16'hFFFF);
    check_output("over_max16", max_16, 17'd131071);
    check_output("over_errc16", errc_16, 16'd256);
    check_output("over_sum32", sum_32, 32'd33554176);

    // bubbles plus ignored start pulses in RUN and DRAIN
    start_window(1'b0);
    feed(1, 1'b1, 1'b1, N);
    finish_window(1'b1);
    check_output("bp_cnt", cnt_32, 16'd256);

    // back-to-back: start in the done cycle
    start_window(1'b1);
    check_output("b2b_clear_sum", sum_32, 32'd0);
    check_output("b2b_clear_cnt", cnt_32, 16'd0);
    feed(0, 1'b0, 1'b0, N);
    finish_window(1'b0);
    check_output("b2b_sum", sum_32, 32'd0);
    check_output("b2b_errc", errc_32, 16'd0);
    check_output("b2b_cnt", cnt_32, 16'd256);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
